// File: rtl/logic_unit_pipe.sv
// Selectable bitwise logic op on WIDTH-bit operands, carried through DEPTH register stages (latency DEPTH).
// Valid/ready handshake: stall propagates combinationally from out_ready; in_ready drops only when every stage is full.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef struct packed {
        logic             vld;
        logic [2:0]       op;
        logic [WIDTH-1:0] dat;
    } stage_t;

    stage_t           stg_q [DEPTH];
    stage_t           stg0_d;
    logic [WIDTH-1:0] res_d;
    logic [DEPTH-1:0] adv;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        res_d = in_a;
        case (in_op)
            3'b000:  res_d = ~in_a;
            3'b001:  res_d = in_a & in_b;
            3'b010:  res_d = in_a | in_b;
            3'b011:  res_d = in_a ^ in_b;
            3'b100:  res_d = ~(in_a & in_b);
            3'b101:  res_d = ~(in_a | in_b);
            3'b110:  res_d = ~(in_a ^ in_b);
            default: res_d = in_a;
        endcase
    end

    // A stage may advance when downstream is draining or any stage at or after it holds a bubble.
    always_comb begin : ready_chain
        logic tail_full;
        tail_full = 1'b1;
        adv       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            tail_full = tail_full & stg_q[k].vld;
            adv[k]    = out_ready | ~tail_full;
        end
    end

    assign stg0_d = {in_valid, in_op, res_d};
    assign cnt_d  = (out_valid && out_ready) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stg_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (adv[0]) begin
                stg_q[0] <= stg0_d;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    stg_q[k] <= stg_q[k-1];
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = stg_q[DEPTH-1].vld;
    assign out_y     = stg_q[DEPTH-1].dat;
    assign out_op    = stg_q[DEPTH-1].op;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench: main instance (DEPTH=2, CNT_W=16) and a DEPTH=1, CNT_W=2 instance share one input stream.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] in_op = '0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;

    logic        m_in_ready, m_out_valid;
    logic [7:0]  m_out_y;
    logic [2:0]  m_out_op;
    logic [15:0] m_beat_cnt;
    logic        w_in_ready, w_out_valid;
    logic [7:0]  w_out_y;
    logic [2:0]  w_out_op;
    logic [1:0]  w_beat_cnt;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) u_main (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_y(m_out_y), .out_op(m_out_op), .beat_cnt(m_beat_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .DEPTH(1), .CNT_W(2)) u_wrap (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_y(w_out_y), .out_op(w_out_op), .beat_cnt(w_beat_cnt)
    );

    typedef struct {
        logic [7:0] y;
        logic [2:0] op;
    } exp_t;

    int          checks = 0;
    int          passed = 0;
    exp_t        q_m[$];
    exp_t        q_w[$];
    exp_t        e;
    logic [7:0]  log_m[$];
    logic [15:0] cnt_m;
    logic [1:0]  cnt_w;
    logic        stall_m, stall_w;
    logic [7:0]  hold_m, hold_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Each op as a 4-entry truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] r;
        case (op)
            3'd0:    tt = 4'b0011;
            3'd1:    tt = 4'b1000;
            3'd2:    tt = 4'b1110;
            3'd3:    tt = 4'b0110;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0001;
            3'd6:    tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // Monitor/scoreboard: values seen at negedge describe the handshakes of the coming posedge.
    always @(negedge clk) begin
        if (!n_rst) begin
            q_m.delete(); q_w.delete();
            cnt_m = '0; cnt_w = '0;
            stall_m = 1'b0; stall_w = 1'b0;
        end else begin
            chk("m_beat_cnt", m_beat_cnt, cnt_m);
            if (stall_m) begin
                chk("m_hold_valid", m_out_valid, 1);
                chk("m_hold_y", m_out_y, hold_m);
            end
            if (m_out_valid && out_ready) begin
                if (q_m.size() == 0) chk("m_unexpected_beat", q_m.size(), 1);
                else begin
                    e = q_m.pop_front();
                    chk("m_out_y", m_out_y, e.y);
                    chk("m_out_op", m_out_op, e.op);
                    log_m.push_back(m_out_y);
                end
                cnt_m = cnt_m + 1'b1;
            end
            stall_m = m_out_valid && !out_ready;
            hold_m  = m_out_y;
            if (in_valid && m_in_ready) q_m.push_back('{ref_y(in_op, in_a, in_b), in_op});

            chk("w_beat_cnt", w_beat_cnt, cnt_w);
            if (stall_w) begin
                chk("w_hold_valid", w_out_valid, 1);
                chk("w_hold_y", w_out_y, hold_w);
            end
            if (w_out_valid && out_ready) begin
                if (q_w.size() == 0) chk("w_unexpected_beat", q_w.size(), 1);
                else begin
                    e = q_w.pop_front();
                    chk("w_out_y", w_out_y, e.y);
                    chk("w_out_op", w_out_op, e.op);
                end
                cnt_w = cnt_w + 1'b1;
            end
            stall_w = w_out_valid && !out_ready;
            hold_w  = w_out_y;
            if (in_valid && w_in_ready) q_w.push_back('{ref_y(in_op, in_a, in_b), in_op});
        end
    end

    logic [7:0] sweep_exp [8] = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5};
    logic [7:0] bp_exp [4]    = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};
    logic [5:0] bub_pat       = 6'b000101;

    initial begin
        int  idx;
        logic acc;

        // Reset held with a beat offered
        n_rst = 1'b0; in_valid = 1'b1; in_op = 3'b011; in_a = 8'h5A; in_b = 8'h0F; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_m_valid", m_out_valid, 0);
            chk("rst_m_y", m_out_y, 0);
            chk("rst_m_cnt", m_beat_cnt, 0);
            chk("rst_w_valid", w_out_valid, 0);
            chk("rst_w_cnt", w_beat_cnt, 0);
        end
        n_rst = 1'b1; in_valid = 1'b0; #1;
        chk("rst_m_in_ready", m_in_ready, 1);
        chk("rst_w_in_ready", w_in_ready, 1);

        // Op sweep, back to back
        @(posedge clk); #1;
        in_a = 8'hA5; in_b = 8'h3C; log_m.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_op = 3'(i);
            @(posedge clk); #1;
            if (i == 0) begin
                chk("lat_m_early", m_out_valid, 0);
                chk("lat_w_valid", w_out_valid, 1);
                chk("lat_w_y", w_out_y, 8'h5A);
            end
            if (i == 1) begin
                chk("lat_m_valid", m_out_valid, 1);
                chk("lat_m_y", m_out_y, 8'h5A);
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("sweep_m_cnt", m_beat_cnt, 8);
        chk("sweep_w_cnt_wrapped", w_beat_cnt, 0);
        chk("sweep_len", log_m.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_m.size()) chk("sweep_y", log_m[i], sweep_exp[i]);

        // Backpressure
        out_ready = 1'b0; log_m.delete(); idx = 0; in_op = 3'b011; in_b = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4); in_a = 8'(idx + 1);
            @(negedge clk); acc = in_valid && m_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        chk("bp_accepts", idx, 2);
        chk("bp_in_ready", m_in_ready, 0);
        chk("bp_valid", m_out_valid, 1);
        chk("bp_y", m_out_y, 8'hFE);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            in_valid = 1'b1; in_a = 8'(idx + 1);
            @(negedge clk); acc = m_in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_accepts_all", idx, 4);
        repeat (4) @(posedge clk); #1;
        chk("bp_len", log_m.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_m.size()) chk("bp_order", log_m[i], bp_exp[i]);

        // Bubbles
        in_op = 3'b111;
        for (int i = 0; i < 6; i++) begin
            in_valid = bub_pat[i]; in_a = 8'(i);
            @(negedge clk);
            chk("bubble_valid", m_out_valid, (i >= 2) ? 32'(bub_pat[i-2]) : 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Reset with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h11;
        @(posedge clk); #1; in_a = 8'h22;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("mid_pre_valid", m_out_valid, 1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1; out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("mid_m_valid", m_out_valid, 0);
            chk("mid_w_valid", w_out_valid, 0);
            chk("mid_m_cnt", m_beat_cnt, 0);
            chk("mid_w_cnt", w_beat_cnt, 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op = 3'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("drain_m", q_m.size(), 0);
        chk("drain_w", q_w.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
